dma_controller: RTL and testbench

//  External DMA engine that moves one fixed-size packet from a device FIFO port into data memory.
//  It collects NUM_BLOCKS*4 16-bit words from the device and interrupts the CPU with dma_begin.

---
 rtl/dma_controller_if.sv | 29 ++
 rtl/dma_controller.sv | 134 +++++++++++++
 tb/tb_dma_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_if.sv
// Device FIFO port, CPU handshake and 64-bit data-memory bus of dma_controller.
// The controller takes the master modport; the system side takes the slave modport.
interface dma_controller_if #(
    parameter int WORD_SIZE  = 16,
    parameter int FETCH_SIZE = 64
);
    logic                  dev_valid;
    logic [WORD_SIZE-1:0]  dev_data;
    logic                  dev_ready;
    logic                  dma_begin;
    logic                  cmd;
    logic                  BR;
    logic                  BG;
    logic                  d_writeM;
    logic [WORD_SIZE-1:0]  d_address;
    logic [FETCH_SIZE-1:0] d_data;
    logic                  dma_end;
    logic                  busy;

    modport master (
        input  dev_valid, dev_data, cmd, BG,
        output dev_ready, dma_begin, BR, d_writeM, d_address, d_data, dma_end, busy
    );

    modport slave (
        output dev_valid, dev_data, cmd, BG,
        input  dev_ready, dma_begin, BR, d_writeM, d_address, d_data, dma_end, busy
    );
endinterface

// File: rtl/dma_controller.sv
// DMA engine: buffers one NUM_BLOCKS*4-word packet from the device, then writes it to memory.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle between blocks (default: burst).
module dma_controller #(
    parameter int                   WORD_SIZE     = 16,
    parameter int                   FETCH_SIZE    = 64,
    parameter int                   NUM_BLOCKS    = 3,
    parameter int                   MEM_LATENCY   = 4,
    parameter logic [WORD_SIZE-1:0] DMA_BASE_ADDR = 16'h01F4
) (
    input logic              Clk,
    input logic              Reset_N,
    dma_controller_if.master bus
);
    localparam int NUM_WORDS = NUM_BLOCKS * 4;
    localparam int PTR_W     = $clog2(NUM_WORDS);
    localparam int BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CYC_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_FILL, S_INTR, S_WAIT_CMD, S_REQ, S_XFER, S_GAP, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [WORD_SIZE-1:0]  pkt_q [NUM_WORDS];
    logic [PTR_W-1:0]      blk_base;
    logic [FETCH_SIZE-1:0] blk_data;
    logic                  accept;
    logic                  owner;
    logic                  last_word;
    logic                  last_cyc;
    logic                  last_blk;

    assign accept    = (state_q == S_FILL) && bus.dev_valid;
    assign owner     = (state_q == S_XFER) && bus.BG;
    assign last_word = (wr_ptr_q == PTR_W'(NUM_WORDS - 1));
    assign last_cyc  = (cyc_q == CYC_W'(MEM_LATENCY - 1));
    assign last_blk  = (blk_q == BLK_W'(NUM_BLOCKS - 1));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            blk_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            blk_q    <= blk_d;
            cyc_q    <= cyc_d;
        end
    end

    // NOTE: the packet buffer has no reset; every word is rewritten before it is read.
    always_ff @(posedge Clk) begin
        if (accept) begin
            pkt_q[wr_ptr_q] <= bus.dev_data;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        blk_d    = blk_q;
        cyc_d    = cyc_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (last_word) begin
                        wr_ptr_d = '0;
                        state_d  = S_INTR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
            end
            S_INTR:     state_d = S_WAIT_CMD;
            S_WAIT_CMD: if (bus.cmd) state_d = S_REQ;
            S_REQ: begin
                if (bus.BG) begin
                    state_d = S_XFER;
                end else if (!bus.cmd) begin
                    state_d = S_WAIT_CMD;
                end
            end
            S_XFER: begin
                // Counters only advance on granted cycles, so a BG drop simply pauses.
                if (bus.BG) begin
                    if (last_cyc) begin
                        cyc_d = '0;
                        if (last_blk) begin
                            blk_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            blk_d = blk_q + BLK_W'(1);
`ifdef DMA_CYCLE_STEAL_EN
                            state_d = S_GAP;
`else
                            state_d = S_XFER;
`endif
                        end
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
            end
            S_GAP:   state_d = S_REQ;
            S_DONE:  state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    assign blk_base = PTR_W'({blk_q, 2'b00});

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 4; i++) begin
            blk_data[i*WORD_SIZE +: WORD_SIZE] = pkt_q[blk_base + PTR_W'(i)];
        end
    end

    assign bus.dev_ready = (state_q == S_FILL);
    assign bus.dma_begin = (state_q == S_INTR);
    assign bus.BR        = (state_q == S_REQ) || (state_q == S_XFER);
    assign bus.d_writeM  = owner;
    assign bus.d_address = owner ? DMA_BASE_ADDR + (WORD_SIZE'(blk_q) << 2) : '0;
    assign bus.d_data    = owner ? blk_data : {FETCH_SIZE{1'bz}};
    assign bus.dma_end   = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_FILL);
endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: fill, burst transfer, BG pause, cmd withdrawal, reset abort.
// Expected per-cycle BG/BR/write patterns are hand-timed tables; DMA_CYCLE_STEAL_EN selects the set.
module tb_dma_controller;
    logic Clk;
    logic Reset_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    dma_controller_if #(.WORD_SIZE(16), .FETCH_SIZE(64)) bus ();

    dma_controller dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus.master)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic bus_idle();
        return (bus.d_data === {64{1'bz}}) || (bus.d_data === 64'd0);
    endfunction

    // Feeds 12 words w0..w0+11; the device keeps offering 0xDEAD afterwards.
    task automatic fill(input logic [15:0] w0);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            bus.dev_valid = 1'b1;
            bus.dev_data  = w0 + 16'(i);
            #1;
            check($sformatf("fill_ready@%0d", i), bus.dev_ready, 1'b1);
            check($sformatf("fill_begin@%0d", i), bus.dma_begin, 1'b0);
        end
        @(negedge Clk);
        bus.dev_data = 16'hDEAD;
        #1;
        check("begin_pulse", bus.dma_begin, 1'b1);
        check("begin_ready", bus.dev_ready, 1'b0);
        check("begin_busy", bus.busy, 1'b1);
        @(negedge Clk);
        #1;
        check("begin_gone", bus.dma_begin, 1'b0);
        check("wait_ready", bus.dev_ready, 1'b0);
    endtask

    // Cycle c drives BG=bg[c]; expects BR=br[c], write=wr[c]; k-th write is block k/4.
    task automatic run_xfer(input int ncyc, input logic [31:0] bg, input logic [31:0] br,
                            input logic [31:0] wr, input logic end_last, input logic [15:0] w0);
        int          k;
        logic [15:0] b4;
        k = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            bus.cmd = 1'b1;
            bus.BG  = bg[c];
            #1;
            check($sformatf("BR@c%0d", c), bus.BR, br[c]);
            check($sformatf("writeM@c%0d", c), bus.d_writeM, wr[c]);
            check($sformatf("ready@c%0d", c), bus.dev_ready, 1'b0);
            check($sformatf("end@c%0d", c), bus.dma_end, end_last && (c == ncyc - 1));
            if (wr[c]) begin
                b4 = w0 + 16'(4 * (k / 4));
                check($sformatf("addr@w%0d", k), bus.d_address, 16'h01F4 + 16'(4 * (k / 4)));
                check($sformatf("data@w%0d", k), bus.d_data,
                      {b4 + 16'd3, b4 + 16'd2, b4 + 16'd1, b4});
                k++;
            end else begin
                check($sformatf("addr_idle@c%0d", c), bus.d_address, 16'h0000);
                check($sformatf("data_z@c%0d", c), bus_idle(), 1'b1);
            end
        end
    endtask

    task automatic after_done();
        @(negedge Clk);
        bus.cmd       = 1'b0;
        bus.BG        = 1'b0;
        bus.dev_valid = 1'b0;
        #1;
        check("post_ready", bus.dev_ready, 1'b1);
        check("post_busy", bus.busy, 1'b0);
        check("post_end", bus.dma_end, 1'b0);
        check("post_BR", bus.BR, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_full, n_pause, n_abort;
        logic [31:0] bg_full, br_full, wr_full;
        logic [31:0] bg_pause, br_pause, wr_pause;
`ifdef DMA_CYCLE_STEAL_EN
        n_full   = 22;
        bg_full  = rng(2, 6) | rng(9, 13) | rng(16, 20);
        br_full  = rng(1, 6) | rng(8, 13) | rng(15, 20);
        wr_full  = rng(3, 6) | rng(10, 13) | rng(17, 20);
        n_pause  = 25;
        bg_pause = rng(2, 6) | rng(9, 11) | rng(15, 16) | rng(19, 23);
        br_pause = rng(1, 6) | rng(8, 16) | rng(18, 23);
        wr_pause = rng(3, 6) | rng(10, 11) | rng(15, 16) | rng(20, 23);
        n_abort  = 18;
`else
        n_full   = 16;
        bg_full  = rng(2, 14);
        br_full  = rng(1, 14);
        wr_full  = rng(3, 14);
        n_pause  = 19;
        bg_pause = rng(2, 8) | rng(12, 17);
        br_pause = rng(1, 17);
        wr_pause = rng(3, 8) | rng(12, 17);
        n_abort  = 13;
`endif
        Reset_N       = 1'b0;
        bus.dev_valid = 1'b0;
        bus.dev_data  = '0;
        bus.cmd       = 1'b0;
        bus.BG        = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_ready", bus.dev_ready, 1'b1);
        check("rst_begin", bus.dma_begin, 1'b0);
        check("rst_BR", bus.BR, 1'b0);
        check("rst_writeM", bus.d_writeM, 1'b0);
        check("rst_addr", bus.d_address, 16'h0000);
        check("rst_end", bus.dma_end, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_data_z", bus_idle(), 1'b1);
        @(negedge Clk);
        Reset_N = 1'b1;

        // Plain transfer, grant one cycle after BR.
        fill(16'h0001);
        run_xfer(n_full, bg_full, br_full, wr_full, 1'b1, 16'h0001);
        after_done();

        // BG withdrawn for 3 cycles in the middle of block 1.
        fill(16'h0011);
        run_xfer(n_pause, bg_pause, br_pause, wr_pause, 1'b1, 16'h0011);
        after_done();

        // cmd withdrawn while requesting, then reasserted.
        fill(16'h0021);
        @(negedge Clk);
        bus.cmd = 1'b1;
        #1;
        check("cmd_wait_BR", bus.BR, 1'b0);
        @(negedge Clk);
        bus.cmd = 1'b0;
        #1;
        check("cmd_req_BR", bus.BR, 1'b1);
        @(negedge Clk);
        #1;
        check("cmd_drop_BR", bus.BR, 1'b0);
        check("cmd_drop_busy", bus.busy, 1'b1);
        run_xfer(n_full, bg_full, br_full, wr_full, 1'b1, 16'h0021);
        after_done();

        // Reset during block 2, then a fresh packet.
        fill(16'h0031);
        run_xfer(n_abort, bg_full, br_full, wr_full, 1'b0, 16'h0031);
        @(negedge Clk);
        Reset_N = 1'b0;
        bus.BG  = 1'b1;
        @(negedge Clk);
        Reset_N       = 1'b1;
        bus.BG        = 1'b0;
        bus.cmd       = 1'b0;
        bus.dev_valid = 1'b0;
        #1;
        check("abort_BR", bus.BR, 1'b0);
        check("abort_writeM", bus.d_writeM, 1'b0);
        check("abort_end", bus.dma_end, 1'b0);
        check("abort_ready", bus.dev_ready, 1'b1);
        check("abort_data_z", bus_idle(), 1'b1);
        fill(16'h0101);
        run_xfer(n_full, bg_full, br_full, wr_full, 1'b1, 16'h0101);
        after_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
